regfile_mp: RTL and testbench

Parametrised multi-read-port integer register file for the pipelined RISC-V core; successor of the fixed 2R1W 32×32 file. Adds configurable width, depth and read-port count, hardwired-zero register 0, optional write-to-read bypass, and a post-reset scrub sequencer that clears every register and reports readiness, so the array never holds X after reset. It sits in the decode stage: reads feed the operand registers and the single write comes from writeback.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_scrub_ctrl.sv | 48 ++++
 rtl/regfile_mp.sv | 89 ++++++++
 tb/tb_regfile_mp.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg
// Shared types and constants for the multi-port register file.
//   state_t     : scrub sequencer states (SCRUB clears the array, READY is normal use)
//   ZERO_REG    : address of the hardwired-zero register
//   addr_width(): address width for a given register count
package regfile_pkg;

    typedef enum logic {
        SCRUB = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int ZERO_REG = 0;

    function automatic int addr_width(input int nregs);
        return $clog2(nregs);
    endfunction

endpackage

// File: rtl/regfile_scrub_ctrl.sv
// regfile_scrub_ctrl
// Post-reset scrub sequencer. Walks addresses 1..NREGS-1, zeroing one register
// per clock, then parks in READY. Register 0 is never stored, so it is skipped.
// Ports:
//   clk        : clock
//   rst        : asynchronous active-high reset, restarts the scrub
//   scrub_we   : array write enable requested by the scrub
//   scrub_addr : array address being cleared
//   ready      : high once every register has been cleared
module regfile_scrub_ctrl
    import regfile_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    output logic          scrub_we,
    output logic [AW-1:0] scrub_addr,
    output logic          ready
);

    state_t        state;
    logic [AW-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its inputs from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SCRUB;
            cnt   <= AW'(1);
        end else if (state == SCRUB) begin
            // The last address is cleared on the same edge that enters READY;
            // the counter then holds rather than wrapping.
            if (cnt == AW'(NREGS - 1)) begin
                state <= READY;
            end else begin
                cnt <= cnt + AW'(1);
            end
        end
    end

    // Gate with rst so no array write is issued while reset is held.
    assign scrub_we   = (state == SCRUB) && !rst;
    assign scrub_addr = cnt;
    assign ready      = (state == READY);

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
// Parametrised integer register file: NREAD combinational read ports, one
// write port, hardwired-zero x0, optional write-to-read bypass, and a scrub
// sequencer that clears the array after every reset.
// Ports:
//   clk   : clock
//   rst   : asynchronous active-high reset
//   ra    : read addresses, port i at [i*AW +: AW]
//   rd    : read data, port i at [i*XLEN +: XLEN], combinational
//   we    : write enable
//   wa    : write address
//   wd    : write data
//   ready : high once the scrub has finished and the file is usable
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN   = 32,
    parameter  int NREGS  = 32,
    parameter  int NREAD  = 2,
    parameter  bit BYPASS = 1'b1,
    localparam int AW     = addr_width(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREAD*AW-1:0]   ra,
    output logic [NREAD*XLEN-1:0] rd,
    input  logic                  we,
    input  logic [AW-1:0]         wa,
    input  logic [XLEN-1:0]       wd,
    output logic                  ready
);

    logic            scrub_we;
    logic [AW-1:0]   scrub_addr;
    logic            arr_we;
    logic [AW-1:0]   arr_wa;
    logic [XLEN-1:0] arr_wd;

    regfile_scrub_ctrl #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scrub (
        .clk        (clk),
        .rst        (rst),
        .scrub_we   (scrub_we),
        .scrub_addr (scrub_addr),
        .ready      (ready)
    );

    // Single array write port: the scrub owns it until ready, after which
    // external writes pass through. External writes during scrub are dropped.
    assign arr_we = ready ? we : scrub_we;
    assign arr_wa = ready ? wa : scrub_addr;
    assign arr_wd = ready ? wd : '0;

    // x0 is not stored; the array starts at index 1.
    logic [XLEN-1:0] mem [1:NREGS-1];

    // NOTE: the storage array deliberately has no reset; clearing it is the
    // scrub sequencer's job, which keeps the array mappable to plain RAM/flops.
    always_ff @(posedge clk) begin
        if (arr_we && (arr_wa != AW'(ZERO_REG))) begin
            mem[arr_wa] <= arr_wd;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;

        assign addr = ra[i*AW +: AW];

        // NOTE: the output gets a default first so every path assigns it and
        // no latch is inferred.
        always_comb begin
            data = '0;
            if (ready && (addr != AW'(ZERO_REG))) begin
                if (BYPASS && we && (wa == addr)) begin
                    data = wd;
                end else begin
                    data = mem[addr];
                end
            end
        end

        assign rd[i*XLEN +: XLEN] = data;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
// Directed bench for regfile_mp. Three instances share clock, reset and the
// write port:
//   dut_a : default config (32 regs, 2 read ports, bypass on)
//   dut_b : 32 regs, 2 read ports, bypass off
//   dut_c : 16 regs, 3 read ports, bypass on
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit
// later, well away from either clock edge.
module tb_regfile_mp;

    logic         clk = 1'b0;
    logic         rst;
    logic         we;
    logic [4:0]   wa;
    logic [31:0]  wd;
    logic [9:0]   ra;
    logic [11:0]  ra_c;
    logic [63:0]  rd_a;
    logic [63:0]  rd_b;
    logic [95:0]  rd_c;
    logic         ready_a;
    logic         ready_b;
    logic         ready_c;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1'b1)) dut_a (
        .clk (clk), .rst (rst), .ra (ra), .rd (rd_a),
        .we (we), .wa (wa), .wd (wd), .ready (ready_a)
    );

    regfile_mp #(.XLEN(32), .NREGS(32), .NREAD(2), .BYPASS(1'b0)) dut_b (
        .clk (clk), .rst (rst), .ra (ra), .rd (rd_b),
        .we (we), .wa (wa), .wd (wd), .ready (ready_b)
    );

    regfile_mp #(.XLEN(32), .NREGS(16), .NREAD(3), .BYPASS(1'b1)) dut_c (
        .clk (clk), .rst (rst), .ra (ra_c), .rd (rd_c),
        .we (we), .wa (wa[3:0]), .wd (wd), .ready (ready_c)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst  = 1'b1;
        we   = 1'b0;
        wa   = '0;
        wd   = '0;
        ra   = '0;
        ra_c = '0;

        // Reset held for 3 cycles.
        repeat (3) @(posedge clk);
        #1;
        check("reset ready_a", 128'(ready_a), 128'(0));
        check("reset ready_b", 128'(ready_b), 128'(0));
        check("reset ready_c", 128'(ready_c), 128'(0));
        check("reset rd_a",    128'(rd_a),    128'(0));
        check("reset rd_c",    128'(rd_c),    128'(0));

        // Hold an external write to x7 throughout the scrub.
        we   = 1'b1;
        wa   = 5'd7;
        wd   = 32'h0000_0055;
        ra   = {5'd7, 5'd7};
        ra_c = {4'd0, 4'd0, 4'd7};
        rst  = 1'b0;

        for (int k = 1; k <= 31; k++) begin
            step();
            check($sformatf("scrub ready_a edge %0d", k), 128'(ready_a), 128'(k >= 31));
            check($sformatf("scrub ready_b edge %0d", k), 128'(ready_b), 128'(k >= 31));
            check($sformatf("scrub ready_c edge %0d", k), 128'(ready_c), 128'(k >= 15));
            if (k == 10) begin
                check("scrub rd_a no bypass leak", 128'(rd_a), 128'(0));
            end
        end
        we = 1'b0;
        #1;
        // The write was dropped on a/b; c became ready at edge 15 and then
        // accepted the still-held write.
        check("x7 after scrub a", 128'(rd_a), 128'(0));
        check("x7 after scrub b", 128'(rd_b), 128'(0));
        check("x7 held write c",  128'(rd_c), {96'h0, 32'h0000_0055});

        // Sweep every address on both ports.
        for (int i = 0; i < 32; i++) begin
            ra = {5'(31 - i), 5'(i)};
            #1;
            check($sformatf("sweep a %0d", i), 128'(rd_a), 128'(0));
            check($sformatf("sweep b %0d", i), 128'(rd_b), 128'(0));
        end

        // Write/read x5, x6.
        step();
        we = 1'b1; wa = 5'd5; wd = 32'hDEAD_BEEF;
        step();
        wa = 5'd6; wd = 32'h0000_000A;
        step();
        we   = 1'b0;
        ra   = {5'd6, 5'd5};
        ra_c = {4'd5, 4'd6, 4'd5};
        #1;
        check("wr/rd a", 128'(rd_a), {64'h0, 32'h0000_000A, 32'hDEAD_BEEF});
        check("wr/rd b", 128'(rd_b), {64'h0, 32'h0000_000A, 32'hDEAD_BEEF});
        check("wr/rd c", 128'(rd_c), {32'h0, 32'hDEAD_BEEF, 32'h0000_000A, 32'hDEAD_BEEF});

        // Zero register: write attempt, including the bypass cycle.
        step();
        we = 1'b1; wa = 5'd0; wd = 32'hFFFF_FFFF;
        ra = {5'd0, 5'd0};
        #1;
        check("x0 write cycle a", 128'(rd_a), 128'(0));
        step();
        we = 1'b0;
        #1;
        check("x0 after write a", 128'(rd_a), 128'(0));
        check("x0 after write b", 128'(rd_b), 128'(0));

        // Bypass: both ports on the register being written.
        step();
        we   = 1'b1; wa = 5'd9; wd = 32'h1234_5678;
        ra   = {5'd9, 5'd9};
        ra_c = {4'd9, 4'd9, 4'd9};
        #1;
        check("bypass a same cycle",   128'(rd_a), {64'h0, 32'h1234_5678, 32'h1234_5678});
        check("no bypass b same cycle", 128'(rd_b), 128'(0));
        check("bypass c same cycle",   128'(rd_c), {32'h0, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678});
        step();
        we = 1'b0;
        #1;
        check("bypass a next cycle",   128'(rd_a), {64'h0, 32'h1234_5678, 32'h1234_5678});
        check("no bypass b next cycle", 128'(rd_b), {64'h0, 32'h1234_5678, 32'h1234_5678});

        // Mid-operation reset.
        step();
        we = 1'b1; wa = 5'd3; wd = 32'hA5A5_A5A5;
        step();
        we   = 1'b0;
        ra   = {5'd0, 5'd3};
        ra_c = {4'd0, 4'd0, 4'd3};
        #1;
        check("x3 before reset a", 128'(rd_a), {96'h0, 32'hA5A5_A5A5});
        check("x3 before reset c", 128'(rd_c), {96'h0, 32'hA5A5_A5A5});
        rst = 1'b1;
        #1;
        check("async reset ready_a", 128'(ready_a), 128'(0));
        check("async reset ready_c", 128'(ready_c), 128'(0));
        check("async reset rd_a",    128'(rd_a),    128'(0));
        check("async reset rd_c",    128'(rd_c),    128'(0));
        #1;
        rst = 1'b0;

        for (int k = 1; k <= 31; k++) begin
            step();
            check($sformatf("rescrub ready_a edge %0d", k), 128'(ready_a), 128'(k >= 31));
            check($sformatf("rescrub ready_c edge %0d", k), 128'(ready_c), 128'(k >= 15));
        end
        #1;
        check("x3 after rescrub a", 128'(rd_a), 128'(0));
        check("x3 after rescrub b", 128'(rd_b), 128'(0));
        check("x3 after rescrub c", 128'(rd_c), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
